// File: rtl/Public_Info.sv
// Types shared between decode, the issue buffer and dispatch.
// ISSUE_BUF_DEPTH sets the issue_buffer entry count used by the top level.
package Public_Info;

  localparam int ISSUE_BUF_DEPTH = 8;

  typedef struct packed {
    logic [31:0] PC;
    logic [31:0] instr;
    logic        o_valid;
  } PC_set;

  // Dispatch may report 3; the buffer only ever hands out two entries.
  function automatic logic [1:0] clamp_use(input logic [1:0] n);
    return (n == 2'd3) ? 2'd2 : n;
  endfunction

endpackage

// File: rtl/issue_buffer_perf.sv
// Saturating occupancy counters for the issue buffer.
// Compiled only when ISSUE_BUF_PERF_EN is defined.
`ifdef ISSUE_BUF_PERF_EN
module issue_buffer_perf (
  input  logic        clk,
  input  logic        rstn,
  input  logic        empty_i,
  input  logic        stall_i,
  output logic [31:0] o_perf_empty_cyc,
  output logic [31:0] o_perf_stall_cyc
);

  logic [31:0] empty_cyc_q;
  logic [31:0] stall_cyc_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      empty_cyc_q <= '0;
      stall_cyc_q <= '0;
    end else begin
      if (empty_i && (empty_cyc_q != '1)) empty_cyc_q <= empty_cyc_q + 32'd1;
      if (stall_i && (stall_cyc_q != '1)) stall_cyc_q <= stall_cyc_q + 32'd1;
    end
  end

  assign o_perf_empty_cyc = empty_cyc_q;
  assign o_perf_stall_cyc = stall_cyc_q;

endmodule
`endif

// File: rtl/issue_buffer.sv
// Dual-width decode-to-dispatch instruction FIFO: up to two pushes and two pops per cycle.
// Define ISSUE_BUF_PERF_EN to add the empty/stall cycle counters.
module issue_buffer
  import Public_Info::*;
#(
  parameter int DEPTH = ISSUE_BUF_DEPTH
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_flush,
  input  PC_set       i_set1,
  input  PC_set       i_set2,
  input  logic [1:0]  i_valid,
  output logic        o_stall,
  output PC_set       o_set1,
  output PC_set       o_set2,
  output logic [1:0]  o_is_valid,
  input  logic [1:0]  i_usingNUM
`ifdef ISSUE_BUF_PERF_EN
  ,
  output logic [31:0] o_perf_empty_cyc,
  output logic [31:0] o_perf_stall_cyc
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  PC_set         mem_q [DEPTH];

  logic [1:0] push_n;
  logic [1:0] pop_n;
  logic [1:0] use_n;

  // Stall looks only at registered occupancy so dispatch's pop cannot feed back into decode.
  assign o_stall    = (count_q > CW'(DEPTH - 2));
  assign o_is_valid = {(count_q != '0), (count_q > CW'(1))};

  always_comb begin
    push_n  = (o_stall || i_flush) ? 2'd0 : (2'(i_valid[1]) + 2'(i_valid[0]));
    use_n   = clamp_use(i_usingNUM);
    pop_n   = (CW'(use_n) > count_q) ? count_q[1:0] : use_n;
    head_d  = head_q + AW'(pop_n);
    tail_d  = tail_q + AW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (i_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Valid lanes are compacted: the first valid one always lands at tail.
  always_ff @(posedge clk) begin
    if (push_n != 2'd0) begin
      mem_q[tail_q] <= i_valid[1] ? i_set1 : i_set2;
      if (push_n == 2'd2) mem_q[tail_q + AW'(1)] <= i_set2;
    end
  end

  always_comb begin
    o_set1         = mem_q[head_q];
    o_set1.o_valid = o_is_valid[1];
    o_set2         = mem_q[head_q + AW'(1)];
    o_set2.o_valid = o_is_valid[0];
  end

`ifdef ISSUE_BUF_PERF_EN
  issue_buffer_perf u_perf (
    .clk              (clk),
    .rstn             (rstn),
    .empty_i          (count_q == '0),
    .stall_i          (o_stall),
    .o_perf_empty_cyc (o_perf_empty_cyc),
    .o_perf_stall_cyc (o_perf_stall_cyc)
  );
`endif

endmodule

// File: tb/tb_issue_buffer.sv
// Directed table plus randomized run of issue_buffer against a queue-based reference.
// Connects the perf counter ports when ISSUE_BUF_PERF_EN is defined.
module tb_issue_buffer;
  import Public_Info::*;

  localparam int DEPTH = ISSUE_BUF_DEPTH;

  logic       clk = 1'b0;
  logic       rstn;
  logic       i_flush;
  PC_set      i_set1, i_set2, o_set1, o_set2;
  logic [1:0] i_valid, o_is_valid, i_usingNUM;
  logic       o_stall;
`ifdef ISSUE_BUF_PERF_EN
  logic [31:0] perf_empty, perf_stall;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  issue_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_flush    (i_flush),
    .i_set1     (i_set1),
    .i_set2     (i_set2),
    .i_valid    (i_valid),
    .o_stall    (o_stall),
    .o_set1     (o_set1),
    .o_set2     (o_set2),
    .o_is_valid (o_is_valid),
    .i_usingNUM (i_usingNUM)
`ifdef ISSUE_BUF_PERF_EN
    ,
    .o_perf_empty_cyc (perf_empty),
    .o_perf_stall_cyc (perf_stall)
`endif
  );

  typedef struct {
    logic        flush;
    logic [1:0]  v;
    logic [31:0] pc1;
    logic [31:0] pc2;
    logic [1:0]  use_n;
    logic [1:0]  e_isv;
    logic        e_stall;
    logic [31:0] e_pc1;
    logic [31:0] e_pc2;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic f, input logic [1:0] v, input logic [31:0] p1,
                     input logic [31:0] p2, input logic [1:0] u, input logic [1:0] eisv,
                     input logic est, input logic [31:0] ep1, input logic [31:0] ep2);
    vec_t r;
    r.flush = f; r.v = v; r.pc1 = p1; r.pc2 = p2; r.use_n = u;
    r.e_isv = eisv; r.e_stall = est; r.e_pc1 = ep1; r.e_pc2 = ep2;
    tbl.push_back(r);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [1:0] v, input logic [31:0] p1,
                       input logic [31:0] p2, input logic [1:0] u);
    i_flush    = f;
    i_valid    = v;
    i_set1     = '{PC: p1, instr: ~p1, o_valid: 1'b1};
    i_set2     = '{PC: p2, instr: ~p2, o_valid: 1'b1};
    i_usingNUM = u;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [1:0] eisv, input logic est,
                            input logic [31:0] ep1, input logic [31:0] ep2);
    chk({tag, ".is_valid"}, 32'(o_is_valid), 32'(eisv));
    chk({tag, ".stall"}, 32'(o_stall), 32'(est));
    chk({tag, ".set1_valid"}, 32'(o_set1.o_valid), 32'(eisv[1]));
    chk({tag, ".set2_valid"}, 32'(o_set2.o_valid), 32'(eisv[0]));
    if (eisv[1]) chk({tag, ".pc1"}, o_set1.PC, ep1);
    if (eisv[0]) chk({tag, ".pc2"}, o_set2.PC, ep2);
  endtask

  logic [31:0] model_q[$];

  initial begin
    // Directed sequence; expectations derived by hand from the FIFO rules (DEPTH=8).
    add(0, 2'b11, 32'h1c000000, 32'h1c000004, 0, 2'b11, 0, 32'h1c000000, 32'h1c000004);
    add(0, 2'b00, 0, 0, 2, 2'b00, 0, 0, 0);
    add(0, 2'b01, 32'hdead, 32'h20, 0, 2'b10, 0, 32'h20, 0);
    add(0, 2'b10, 32'h24, 32'hbeef, 0, 2'b11, 0, 32'h20, 32'h24);
    add(0, 2'b11, 32'h30, 32'h34, 0, 2'b11, 0, 32'h20, 32'h24);
    add(0, 2'b11, 32'h38, 32'h3c, 0, 2'b11, 0, 32'h20, 32'h24);
    add(0, 2'b01, 32'hdead, 32'h40, 0, 2'b11, 1, 32'h20, 32'h24);
    add(0, 2'b11, 32'h50, 32'h54, 0, 2'b11, 1, 32'h20, 32'h24);
    add(0, 2'b11, 32'h58, 32'h5c, 2, 2'b11, 0, 32'h30, 32'h34);
    add(0, 2'b00, 0, 0, 2, 2'b11, 0, 32'h38, 32'h3c);
    add(0, 2'b11, 32'h60, 32'h64, 2, 2'b11, 0, 32'h40, 32'h60);
    add(0, 2'b00, 0, 0, 2, 2'b10, 0, 32'h64, 0);
    add(0, 2'b00, 0, 0, 2, 2'b00, 0, 0, 0);
    add(0, 2'b00, 0, 0, 3, 2'b00, 0, 0, 0);
    add(0, 2'b11, 32'h70, 32'h74, 0, 2'b11, 0, 32'h70, 32'h74);
    add(0, 2'b11, 32'h78, 32'h7c, 1, 2'b11, 0, 32'h74, 32'h78);
    add(0, 2'b01, 32'hdead, 32'h80, 0, 2'b11, 0, 32'h74, 32'h78);
    add(0, 2'b10, 32'h84, 32'hbeef, 0, 2'b11, 0, 32'h74, 32'h78);
    add(1, 2'b11, 32'ha0, 32'ha4, 1, 2'b00, 0, 0, 0);
    add(0, 2'b11, 32'h90, 32'h94, 3, 2'b11, 0, 32'h90, 32'h94);

    rstn = 1'b0;
    drive(0, 2'b00, 0, 0, 0);
    #12;
    rstn = 1'b1;
    #1;
    $display("reset: is_valid=%b stall=%b", o_is_valid, o_stall);
    check_outs("reset", 2'b00, 1'b0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].flush, tbl[i].v, tbl[i].pc1, tbl[i].pc2, tbl[i].use_n);
      step();
      $display("row %0d: flush=%b v=%b use=%0d -> is_valid=%b stall=%b pc1=%h pc2=%h",
               i, tbl[i].flush, tbl[i].v, tbl[i].use_n, o_is_valid, o_stall,
               o_set1.PC, o_set2.PC);
      check_outs($sformatf("row%0d", i), tbl[i].e_isv, tbl[i].e_stall,
                 tbl[i].e_pc1, tbl[i].e_pc2);
    end

    // Asynchronous reset asserted between clock edges must clear outputs at once.
    drive(0, 2'b11, 32'hc0, 32'hc4, 0);
    #2;
    rstn = 1'b0;
    #1;
    $display("async reset: is_valid=%b stall=%b", o_is_valid, o_stall);
    check_outs("async_rst", 2'b00, 1'b0, 0, 0);
    drive(0, 2'b00, 0, 0, 0);
    #3;
    rstn = 1'b1;
    step();
    check_outs("post_rst", 2'b00, 1'b0, 0, 0);

    // Randomized run: phase 0 pops slowly so the full boundary is exercised.
    model_q.delete();
    for (int n = 0; n < 600; n++) begin
      logic        f;
      logic [1:0]  v, u;
      logic [31:0] p1, p2;
      int          pop;
      logic [1:0]  eisv;
      f  = ($urandom_range(0, 24) == 0);
      v  = 2'($urandom_range(0, 3));
      u  = (n < 300) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      p1 = $urandom & 32'hffff_fffc;
      p2 = $urandom & 32'hffff_fffc;
      drive(f, v, p1, p2, u);

      if (f) begin
        model_q.delete();
      end else begin
        bit full_now;
        full_now = (model_q.size() > DEPTH - 2);
        pop = (u == 2'd3) ? 2 : int'(u);
        if (pop > model_q.size()) pop = model_q.size();
        repeat (pop) void'(model_q.pop_front());
        if (!full_now) begin
          if (v[1]) model_q.push_back(p1);
          if (v[0]) model_q.push_back(p2);
        end
      end

      step();
      eisv = {(model_q.size() >= 1), (model_q.size() >= 2)};
      $display("rnd %0d: flush=%b v=%b use=%0d size=%0d -> is_valid=%b stall=%b",
               n, f, v, u, model_q.size(), o_is_valid, o_stall);
      check_outs($sformatf("rnd%0d", n), eisv, (model_q.size() > DEPTH - 2),
                 (model_q.size() >= 1) ? model_q[0] : 32'h0,
                 (model_q.size() >= 2) ? model_q[1] : 32'h0);
    end

`ifdef ISSUE_BUF_PERF_EN
    $display("perf: empty_cyc=%0d stall_cyc=%0d", perf_empty, perf_stall);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
